// File: rtl/crc16_fault_sequencer.sv
// ----------------------------------------------------------------------------
// crc16_fault_sequencer
//
// Purpose:
//   Hardware fault-sweep controller that sits directly upstream of the
//   crc16_parallel_fault stage. One start request runs a fault-free golden
//   trial followed by 32 faulty trials (stuck-at-0 then stuck-at-1 on each of
//   the 16 data bits, bit 0 first). Each trial clears the CRC stage, pulses
//   enable with the latched pattern and the trial's fault mask/value, waits
//   WAIT_CYCLES, samples crc_out and compares it against the golden CRC.
//   One result is reported per faulty trial along with a running count of
//   detected faults.
//
// Parameters:
//   WAIT_CYCLES     cycles between the enable pulse and the crc_out sample (1-15)
//
// Ports:
//   clk             single clock, rising edge
//   reset           synchronous, active-low (0 = reset)
//   start           one-cycle sweep request, ignored while busy
//   pattern         test word, latched on the accepted start
//   crc_clear       synchronous clear to the CRC stage
//   crc_enable      CRC stage enable, one cycle per trial
//   crc_data        CRC stage data_in
//   fault_mask      CRC stage fault_mask
//   fault_value     CRC stage fault_value
//   crc_out         CRC result from the stage
//   busy            high from the cycle after an accepted start through DONE
//   done            one-cycle pulse at sweep end
//   result_valid    one-cycle pulse per faulty trial
//   result_bit      faulted bit index of the reported trial
//   result_type     0 = stuck-at-0, 1 = stuck-at-1
//   result_crc      crc_out sampled for the reported trial
//   result_detected result_crc differs from golden_crc
//   golden_crc      CRC from the fault-free trial
//   detect_count    number of detected faults in this sweep (0-32)
// ----------------------------------------------------------------------------
module crc16_fault_sequencer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pattern,
    output logic        crc_clear,
    output logic        crc_enable,
    output logic [15:0] crc_data,
    output logic [15:0] fault_mask,
    output logic [15:0] fault_value,
    input  logic [15:0] crc_out,
    output logic        busy,
    output logic        done,
    output logic        result_valid,
    output logic [3:0]  result_bit,
    output logic        result_type,
    output logic [15:0] result_crc,
    output logic        result_detected,
    output logic [15:0] golden_crc,
    output logic [5:0]  detect_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_WAIT,
        S_CAPTURE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
    localparam logic [5:0] LAST_TRIAL = 6'd32;

    state_t      state;
    state_t      next_state;

    logic [15:0] pattern_q;
    logic [5:0]  trial;
    logic [3:0]  wait_cnt;

    logic [15:0] golden_crc_q;
    logic        result_valid_q;
    logic [3:0]  result_bit_q;
    logic        result_type_q;
    logic [15:0] result_crc_q;
    logic        result_detected_q;
    logic [5:0]  detect_count_q;

    logic [4:0]  fault_idx;
    logic [3:0]  fault_bit;
    logic        fault_type;
    logic [15:0] fault_onehot;
    logic        fault_active;
    logic        crc_differs;

    // Trial k (1..32) maps to fault index k-1: bit = index>>1, type = index&1.
    // Only the low five bits of the trial are used; trial 32 wraps to 0 and
    // the subtraction brings it back to 31 (bit 15, stuck-at-1). Trial 0 is
    // the golden run and is excluded through fault_active below.
    assign fault_idx    = trial[4:0] - 5'd1;
    assign fault_bit    = fault_idx[4:1];
    assign fault_type   = fault_idx[0];
    assign fault_onehot = 16'd1 << fault_bit;
    assign fault_active = (trial != 6'd0) &&
                          ((state == S_LOAD) || (state == S_WAIT) || (state == S_CAPTURE));
    assign crc_differs  = (crc_out != golden_crc_q);

    // State register; reset returns to IDLE which decodes to all-zero outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore output decode. The fault mask/value are held for
    // the whole LOAD..CAPTURE window so the stage sees a stable fault while
    // its result settles, and drop back to zero in NEXT.
    always_comb begin
        next_state  = state;
        crc_clear   = 1'b0;
        crc_enable  = 1'b0;
        crc_data    = 16'd0;
        done        = 1'b0;
        busy        = (state != S_IDLE);
        fault_mask  = fault_active ? fault_onehot : 16'd0;
        fault_value = (fault_active && fault_type) ? fault_onehot : 16'd0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                crc_clear  = 1'b1;
                next_state = S_LOAD;
            end
            S_LOAD: begin
                crc_enable = 1'b1;
                crc_data   = pattern_q;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                next_state = S_NEXT;
            end
            S_NEXT: begin
                next_state = (trial == LAST_TRIAL) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: pattern latch, trial index, wait counter and result capture.
    // The wait counter is loaded in LOAD so WAIT lasts exactly WAIT_CYCLES
    // cycles. Results land at the end of CAPTURE so result_valid and the
    // updated detect_count are both visible in the NEXT cycle. Golden CRC
    // and results persist after DONE; only detect_count is cleared on start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pattern_q         <= 16'd0;
            trial             <= 6'd0;
            wait_cnt          <= 4'd0;
            golden_crc_q      <= 16'd0;
            result_valid_q    <= 1'b0;
            result_bit_q      <= 4'd0;
            result_type_q     <= 1'b0;
            result_crc_q      <= 16'd0;
            result_detected_q <= 1'b0;
            detect_count_q    <= 6'd0;
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pattern_q      <= pattern;
                        trial          <= 6'd0;
                        detect_count_q <= 6'd0;
                    end
                end
                S_LOAD: begin
                    wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    if (trial == 6'd0) begin
                        golden_crc_q <= crc_out;
                    end else begin
                        result_valid_q    <= 1'b1;
                        result_bit_q      <= fault_bit;
                        result_type_q     <= fault_type;
                        result_crc_q      <= crc_out;
                        result_detected_q <= crc_differs;
                        if (crc_differs) begin
                            detect_count_q <= detect_count_q + 6'd1;
                        end
                    end
                end
                S_NEXT: begin
                    if (trial != LAST_TRIAL) begin
                        trial <= trial + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign golden_crc      = golden_crc_q;
    assign result_valid    = result_valid_q;
    assign result_bit      = result_bit_q;
    assign result_type     = result_type_q;
    assign result_crc      = result_crc_q;
    assign result_detected = result_detected_q;
    assign detect_count    = detect_count_q;

endmodule

// File: tb/tb_crc16_fault_sequencer.sv
// ----------------------------------------------------------------------------
// tb_crc16_fault_sequencer
//
// Purpose:
//   Directed bench for crc16_fault_sequencer. Three sequencer instances
//   (WAIT_CYCLES = 2, 1, 15) each drive a behavioural CRC-16/CCITT stage in
//   which the fault forces data_in bits. Each feature has its own test task
//   with inline comparisons against bench-computed expectations.
// ----------------------------------------------------------------------------
module tb_crc16_fault_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        start_w;
    logic [15:0] pattern;
    logic        const_mode;

    // Main instance (WAIT_CYCLES = 2)
    logic        crc_clear, crc_enable, busy, done, result_valid, result_type, result_detected;
    logic [15:0] crc_data, fault_mask, fault_value, crc_out, result_crc, golden_crc;
    logic [3:0]  result_bit;
    logic [5:0]  detect_count;

    // WAIT_CYCLES = 1 instance
    logic        crc_clear_w1, crc_enable_w1, busy_w1, done_w1, rv_w1, rt_w1, rd_w1;
    logic [15:0] crc_data_w1, mask_w1, value_w1, crc_out_w1, rc_w1, golden_w1;
    logic [3:0]  rb_w1;
    logic [5:0]  dc_w1;

    // WAIT_CYCLES = 15 instance
    logic        crc_clear_w15, crc_enable_w15, busy_w15, done_w15, rv_w15, rt_w15, rd_w15;
    logic [15:0] crc_data_w15, mask_w15, value_w15, crc_out_w15, rc_w15, golden_w15;
    logic [3:0]  rb_w15;
    logic [5:0]  dc_w15;

    int checks = 0;
    int errors = 0;

    // CRC-16/CCITT, polynomial 0x1021, one 16-bit word MSB first
    function automatic logic [15:0] crc16_word(input logic [15:0] c_in, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Behavioural CRC stages: crc_clear is ORed into the stage reset
    logic [15:0] crc_reg, crc_reg_w1, crc_reg_w15;

    always_ff @(posedge clk) begin
        if (!reset || crc_clear) crc_reg <= 16'hFFFF;
        else if (crc_enable) crc_reg <= crc16_word(crc_reg, (crc_data & ~fault_mask) | (fault_value & fault_mask));
    end
    assign crc_out = const_mode ? 16'h1234 : crc_reg;

    always_ff @(posedge clk) begin
        if (!reset || crc_clear_w1) crc_reg_w1 <= 16'hFFFF;
        else if (crc_enable_w1) crc_reg_w1 <= crc16_word(crc_reg_w1, (crc_data_w1 & ~mask_w1) | (value_w1 & mask_w1));
    end
    assign crc_out_w1 = crc_reg_w1;

    always_ff @(posedge clk) begin
        if (!reset || crc_clear_w15) crc_reg_w15 <= 16'hFFFF;
        else if (crc_enable_w15) crc_reg_w15 <= crc16_word(crc_reg_w15, (crc_data_w15 & ~mask_w15) | (value_w15 & mask_w15));
    end
    assign crc_out_w15 = crc_reg_w15;

    crc16_fault_sequencer #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .crc_clear(crc_clear), .crc_enable(crc_enable), .crc_data(crc_data),
        .fault_mask(fault_mask), .fault_value(fault_value), .crc_out(crc_out),
        .busy(busy), .done(done), .result_valid(result_valid), .result_bit(result_bit),
        .result_type(result_type), .result_crc(result_crc), .result_detected(result_detected),
        .golden_crc(golden_crc), .detect_count(detect_count)
    );

    crc16_fault_sequencer #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(reset), .start(start_w), .pattern(pattern),
        .crc_clear(crc_clear_w1), .crc_enable(crc_enable_w1), .crc_data(crc_data_w1),
        .fault_mask(mask_w1), .fault_value(value_w1), .crc_out(crc_out_w1),
        .busy(busy_w1), .done(done_w1), .result_valid(rv_w1), .result_bit(rb_w1),
        .result_type(rt_w1), .result_crc(rc_w1), .result_detected(rd_w1),
        .golden_crc(golden_w1), .detect_count(dc_w1)
    );

    crc16_fault_sequencer #(.WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .reset(reset), .start(start_w), .pattern(pattern),
        .crc_clear(crc_clear_w15), .crc_enable(crc_enable_w15), .crc_data(crc_data_w15),
        .fault_mask(mask_w15), .fault_value(value_w15), .crc_out(crc_out_w15),
        .busy(busy_w15), .done(done_w15), .result_valid(rv_w15), .result_bit(rb_w15),
        .result_type(rt_w15), .result_crc(rc_w15), .result_detected(rd_w15),
        .golden_crc(golden_w15), .detect_count(dc_w15)
    );

    // Records from the most recent run of the main instance
    int          n_res, n_done, done_idx, n_en;
    logic [3:0]  r_bit [40];
    logic        r_type[40];
    logic [15:0] r_crc [40];
    logic        r_det [40];
    int          r_idx [40];
    logic        busy_i0, busy_i1, clear_i1, busy_tail;
    logic [96:0] after_rst;

    // Runs the main instance for up to max_idx cycles, recording outputs at
    // each falling edge. Index 0 is the cycle start is high. Extra start
    // pulses land at pa/pb, a reset pulse at rst_at (-1 disables each).
    task automatic run_main(input int pa, input int pb, input int rst_at, input int max_idx);
        n_res = 0; n_done = 0; done_idx = -1; n_en = 0;
        busy_i0 = 1'bx; busy_i1 = 1'bx; clear_i1 = 1'bx; busy_tail = 1'bx;
        after_rst = '1;
        for (int idx = 0; idx < max_idx; idx++) begin
            @(negedge clk);
            start = (idx == 0) || (idx == pa) || (idx == pb);
            reset = (idx == rst_at) ? 1'b0 : 1'b1;
            if (idx == 0) busy_i0 = busy;
            if (idx == 1) begin busy_i1 = busy; clear_i1 = crc_clear; end
            if (rst_at >= 0 && idx == rst_at + 1)
                after_rst = {busy, done, result_valid, crc_enable, crc_clear, crc_data, fault_mask,
                             fault_value, golden_crc, result_crc, result_bit, result_type,
                             result_detected, detect_count};
            if (result_valid) begin
                if (n_res < 40) begin
                    r_bit[n_res] = result_bit; r_type[n_res] = result_type;
                    r_crc[n_res] = result_crc; r_det[n_res] = result_detected;
                    r_idx[n_res] = idx;
                end
                n_res++;
            end
            if (crc_enable) n_en++;
            if (done) begin
                n_done++;
                if (done_idx < 0) done_idx = idx;
            end
            if (done_idx >= 0 && idx == done_idx + 1) busy_tail = busy;
            if (done_idx >= 0 && idx >= done_idx + 8) break;
        end
        start = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        logic [96:0] snap;
        @(negedge clk);
        reset = 1'b0; start = 1'b1; pattern = 16'hA5A5;
        @(negedge clk);
        @(negedge clk);
        snap = {busy, done, result_valid, crc_enable, crc_clear, crc_data, fault_mask,
                fault_value, golden_crc, result_crc, result_bit, result_type,
                result_detected, detect_count};
        checks++;
        if (snap !== 97'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", snap);
        end
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wins_over_start busy: got %b expected 0", busy);
        end
    endtask

    // Full sweep checks shared by the A5A5 and 0000 scenarios
    task automatic test_sweep(input logic [15:0] pat);
        logic [3:0]  eb;
        logic        et, edet;
        logic [15:0] one, fd, gold;
        pattern = pat;
        run_main(-1, -1, -1, 260);
        gold = crc16_word(16'hFFFF, pat);
        checks++; if (busy_i0 !== 1'b0) begin errors++; $display("[TB] FAIL busy_before: got %b expected 0", busy_i0); end
        checks++; if (busy_i1 !== 1'b1) begin errors++; $display("[TB] FAIL busy_n_plus_1: got %b expected 1", busy_i1); end
        checks++; if (clear_i1 !== 1'b1) begin errors++; $display("[TB] FAIL clear_n_plus_1: got %b expected 1", clear_i1); end
        checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL done_count: got %0d expected 1", n_done); end
        checks++; if (done_idx !== 199) begin errors++; $display("[TB] FAIL done_cycle: got %0d expected 199", done_idx); end
        checks++; if (n_res !== 32) begin errors++; $display("[TB] FAIL result_count: got %0d expected 32", n_res); end
        checks++; if (n_en !== 33) begin errors++; $display("[TB] FAIL enable_count: got %0d expected 33", n_en); end
        checks++; if (busy_tail !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_done: got %b expected 0", busy_tail); end
        checks++; if (golden_crc !== gold) begin errors++; $display("[TB] FAIL golden_crc: got %h expected %h", golden_crc, gold); end
        checks++; if (detect_count !== 6'd16) begin errors++; $display("[TB] FAIL detect_count: got %0d expected 16", detect_count); end
        for (int i = 0; i < 32 && i < n_res; i++) begin
            eb   = 4'(i >> 1);
            et   = 1'(i & 1);
            one  = 16'd1 << eb;
            fd   = et ? (pat | one) : (pat & ~one);
            edet = (et != pat[eb]);
            checks++; if (r_bit[i] !== eb) begin errors++; $display("[TB] FAIL trial%0d bit: got %0d expected %0d", i, r_bit[i], eb); end
            checks++; if (r_type[i] !== et) begin errors++; $display("[TB] FAIL trial%0d type: got %b expected %b", i, r_type[i], et); end
            checks++; if (r_crc[i] !== crc16_word(16'hFFFF, fd)) begin errors++; $display("[TB] FAIL trial%0d crc: got %h expected %h", i, r_crc[i], crc16_word(16'hFFFF, fd)); end
            checks++; if (r_det[i] !== edet) begin errors++; $display("[TB] FAIL trial%0d detected: got %b expected %b", i, r_det[i], edet); end
            checks++; if (r_idx[i] !== 12 + 6 * i) begin errors++; $display("[TB] FAIL trial%0d result_cycle: got %0d expected %0d", i, r_idx[i], 12 + 6 * i); end
        end
    endtask

    task automatic test_const_crc;
        const_mode = 1'b1;
        pattern = 16'hFFFF;
        run_main(-1, -1, -1, 260);
        checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL const_done: got %0d expected 1", n_done); end
        checks++; if (n_res !== 32) begin errors++; $display("[TB] FAIL const_results: got %0d expected 32", n_res); end
        checks++; if (detect_count !== 6'd0) begin errors++; $display("[TB] FAIL const_detect_count: got %0d expected 0", detect_count); end
        checks++; if (golden_crc !== 16'h1234) begin errors++; $display("[TB] FAIL const_golden: got %h expected 1234", golden_crc); end
        for (int i = 0; i < 32 && i < n_res; i++) begin
            checks++;
            if (r_crc[i] !== 16'h1234 || r_det[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL const_trial%0d: got crc %h det %b expected 1234/0", i, r_crc[i], r_det[i]);
            end
        end
        const_mode = 1'b0;
    endtask

    task automatic test_reset_mid_sweep;
        pattern = 16'hA5A5;
        // Trial 10 occupies cycles 61..66; its WAIT starts at cycle 63
        run_main(-1, -1, 63, 250);
        checks++; if (after_rst !== 97'd0) begin errors++; $display("[TB] FAIL midreset_outputs: got %h expected 0", after_rst); end
        checks++; if (n_done !== 0) begin errors++; $display("[TB] FAIL midreset_done: got %0d expected 0", n_done); end
        checks++; if (n_res !== 9) begin errors++; $display("[TB] FAIL midreset_results: got %0d expected 9", n_res); end
        run_main(-1, -1, -1, 260);
        checks++; if (n_res !== 32) begin errors++; $display("[TB] FAIL rerun_results: got %0d expected 32", n_res); end
        checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL rerun_done: got %0d expected 1", n_done); end
        checks++; if (detect_count !== 6'd16) begin errors++; $display("[TB] FAIL rerun_detect_count: got %0d expected 16", detect_count); end
    endtask

    task automatic test_back_to_back;
        pattern = 16'hA5A5;
        run_main(50, 199, -1, 260);
        checks++; if (n_res !== 32) begin errors++; $display("[TB] FAIL restart_results: got %0d expected 32", n_res); end
        checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL restart_done: got %0d expected 1", n_done); end
        checks++; if (done_idx !== 199) begin errors++; $display("[TB] FAIL restart_done_cycle: got %0d expected 199", done_idx); end
        checks++; if (busy_tail !== 1'b0) begin errors++; $display("[TB] FAIL restart_busy_after_done: got %b expected 0", busy_tail); end
        checks++; if (detect_count !== 6'd16) begin errors++; $display("[TB] FAIL restart_detect_count: got %0d expected 16", detect_count); end
    endtask

    task automatic test_wait_variants;
        int nr1, nr15, prev1, prev15, sp1, sp15, ne1, ne15, ec1, ec15;
        int mc1, mc15, mchg1, mchg15, d1, d15;
        logic        pe1, pe15;
        logic [15:0] pm1, pm15;
        nr1 = 0; nr15 = 0; prev1 = -1; prev15 = -1; sp1 = 0; sp15 = 0;
        ne1 = 0; ne15 = 0; ec1 = 0; ec15 = 0; mc1 = 0; mc15 = 0;
        mchg1 = 0; mchg15 = 0; d1 = -1; d15 = -1;
        pe1 = 1'b0; pe15 = 1'b0; pm1 = 16'd0; pm15 = 16'd0;
        pattern = 16'h3C5A;
        for (int idx = 0; idx < 640; idx++) begin
            @(negedge clk);
            start_w = (idx == 0);
            if (rv_w1) begin
                if (prev1 >= 0 && idx - prev1 != 5) sp1++;
                prev1 = idx; nr1++;
            end
            if (rv_w15) begin
                if (prev15 >= 0 && idx - prev15 != 19) sp15++;
                prev15 = idx; nr15++;
            end
            if (crc_enable_w1) ne1++;
            if (crc_enable_w15) ne15++;
            if (crc_enable_w1 && pe1) ec1++;
            if (crc_enable_w15 && pe15) ec15++;
            pe1 = crc_enable_w1; pe15 = crc_enable_w15;
            if (mask_w1 != 16'd0) begin
                mc1++;
                if (pm1 != 16'd0 && mask_w1 != pm1) mchg1++;
                if (value_w1 != 16'd0 && value_w1 != mask_w1) mchg1++;
            end
            if (mask_w15 != 16'd0) begin
                mc15++;
                if (pm15 != 16'd0 && mask_w15 != pm15) mchg15++;
                if (value_w15 != 16'd0 && value_w15 != mask_w15) mchg15++;
            end
            pm1 = mask_w1; pm15 = mask_w15;
            if (done_w1 && d1 < 0) d1 = idx;
            if (done_w15 && d15 < 0) d15 = idx;
        end
        start_w = 1'b0;
        checks++; if (nr1 !== 32) begin errors++; $display("[TB] FAIL w1_results: got %0d expected 32", nr1); end
        checks++; if (nr15 !== 32) begin errors++; $display("[TB] FAIL w15_results: got %0d expected 32", nr15); end
        checks++; if (sp1 !== 0) begin errors++; $display("[TB] FAIL w1_spacing: got %0d bad gaps expected 0", sp1); end
        checks++; if (sp15 !== 0) begin errors++; $display("[TB] FAIL w15_spacing: got %0d bad gaps expected 0", sp15); end
        checks++; if (ne1 !== 33 || ec1 !== 0) begin errors++; $display("[TB] FAIL w1_enable: got %0d pulses %0d doubles expected 33/0", ne1, ec1); end
        checks++; if (ne15 !== 33 || ec15 !== 0) begin errors++; $display("[TB] FAIL w15_enable: got %0d pulses %0d doubles expected 33/0", ne15, ec15); end
        checks++; if (mc1 !== 96) begin errors++; $display("[TB] FAIL w1_mask_cycles: got %0d expected 96", mc1); end
        checks++; if (mc15 !== 544) begin errors++; $display("[TB] FAIL w15_mask_cycles: got %0d expected 544", mc15); end
        checks++; if (mchg1 !== 0 || mchg15 !== 0) begin errors++; $display("[TB] FAIL mask_hold: got %0d/%0d changes expected 0/0", mchg1, mchg15); end
        checks++; if (d1 !== 166) begin errors++; $display("[TB] FAIL w1_done_cycle: got %0d expected 166", d1); end
        checks++; if (d15 !== 628) begin errors++; $display("[TB] FAIL w15_done_cycle: got %0d expected 628", d15); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start_w = 1'b0; pattern = 16'd0; const_mode = 1'b0;
        test_reset();
        test_sweep(16'hA5A5);
        test_sweep(16'h0000);
        test_const_crc();
        test_reset_mid_sweep();
        test_back_to_back();
        test_wait_variants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc16_fault_sequencer.md
# crc16_fault_sequencer

Hardware fault-sweep controller directly upstream of `crc16_parallel_fault`. On `start` it runs one fault-free golden trial, then 32 faulty trials: stuck-at-0 and stuck-at-1 on each of the 16 data bits. For each trial it drives the CRC stage's `enable`, `data_in`, `fault_mask` and `fault_value` ports, samples `crc_out`, and compares the result against the golden CRC. It reports one result per faulty trial and a running detection count, replacing the simulation-only sweep so the campaign can run on silicon or FPGA.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: cycles between the enable pulse and the `crc_out` sample; legal range 1–15.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low; 0 = reset.
- `start`  in  1  one-cycle request to begin a sweep; ignored while `busy`.
- `pattern`  in  16  test word, latched on the accepted `start`.
- `crc_clear`  out  1  synchronous clear to the CRC stage; the top level ORs it into that stage's reset.
- `crc_enable`  out  1  drives CRC stage `enable`.
- `crc_data`  out  16  drives CRC stage `data_in`.
- `fault_mask`  out  16  drives CRC stage `fault_mask`.
- `fault_value`  out  16  drives CRC stage `fault_value`.
- `crc_out`  in  16  from CRC stage.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE state.
- `done`  out  1  one-cycle pulse at sweep end.
- `result_valid`  out  1  one-cycle pulse per faulty trial.
- `result_bit`  out  4  faulted bit index.
- `result_type`  out  1  0 = stuck-at-0, 1 = stuck-at-1.
- `result_crc`  out  16  `crc_out` sampled for this trial.
- `result_detected`  out  1  `result_crc != golden_crc`.
- `golden_crc`  out  16  CRC from the fault-free trial.
- `detect_count`  out  6  number of detected faults, 0–32.

## Operation
States: IDLE, CLEAR, LOAD, WAIT, CAPTURE, NEXT, DONE.

- IDLE: waits for `start`. On `start`, it latches `pattern`, zeroes `detect_count`, sets trial index = 0 (golden), and moves to CLEAR.
- CLEAR: `crc_clear` = 1 for 1 cycle, then LOAD.
- LOAD: `crc_enable` = 1 for 1 cycle, `crc_data` = latched pattern, and mask/value per trial, then WAIT.
  - Golden trial: mask = value = 0.
  - Faulty trial k (1–32): bit b = (k−1)>>1, type t = (k−1)&1, mask = 1<<b, value = t ? 1<<b : 0.
  - Order matches the bench sweep: bit0 sa0, bit0 sa1, bit1 sa0, … bit15 sa1.
- WAIT: stays for `WAIT_CYCLES` cycles, with a 4-bit down-counter loaded on entry. `crc_enable` = 0. Mask/value hold their LOAD values.
- CAPTURE: 1 cycle; samples `crc_out`.
  - Golden trial: loads `golden_crc`; no `result_valid`.
  - Faulty trial: registers the `result_*` fields and pulses `result_valid` the following cycle. `detect_count` increments in that same cycle when the fault is detected.
- NEXT: if the index = 32, go to DONE; otherwise increment the index and go to CLEAR. Mask/value return to 0 here.
- DONE: `done` = 1 for 1 cycle, then IDLE, with `busy` falling.

Holding rules:
- `golden_crc`, the `result_*` fields and `detect_count` hold until the next accepted `start`.
- `detect_count` saturates at 32 by construction, since there are only 32 trials.

## Timing
- Reset (`reset` = 0 at an edge): every output is 0 on the following cycle. This includes `busy`, `done`, `result_valid`, `crc_enable`, `crc_clear`, mask, value, `crc_data`, `golden_crc`, `result_*` and `detect_count`. State = IDLE.
- Reset mid-sweep: aborts immediately; there is no `done` pulse and no partial result pulse.
- `start` in cycle N: `busy` = 1 and `crc_clear` = 1 in cycle N+1.
- Per trial: 3 + `WAIT_CYCLES` cycles for CLEAR + LOAD + WAIT + CAPTURE, plus 1 for NEXT.
- Full sweep: 33 × (4 + `WAIT_CYCLES`) cycles from the first CLEAR to DONE. With `WAIT_CYCLES` = 2, `done` pulses at cycle N+1+198.
- `result_valid` for a trial falls in its NEXT cycle; consecutive pulses are 4 + `WAIT_CYCLES` cycles apart.
- `start` while `busy` or in the DONE cycle is dropped, with no queuing.
- `start` and `reset` = 0 in the same cycle: reset wins.

## Test plan
All scenarios use a bench CRC stage model in which the fault forces `data_in` bits: `data_in` = (d & ~mask) | (value & mask).

1. Reset with `pattern` = A5A5 then `start`, `WAIT_CYCLES` = 2 -> 32 `result_valid` pulses in order bit0/sa0 … bit15/sa1. `done` at start+199. `detect_count` = 16. `result_detected` = 0 exactly on trials where the value bit equals the A5A5 bit (e.g. bit0 sa1, bit1 sa0).
2. `pattern` = 0000 -> all sa0 trials undetected, all sa1 trials detected, `detect_count` = 16. `golden_crc` equals the model CRC of 0000.
3. `pattern` = FFFF, with the CRC stage model tied to constant `crc_out` = 1234 -> `detect_count` = 0, every `result_crc` = 1234, `done` still pulses.
4. Assert `reset` = 0 during trial 10's WAIT -> all outputs 0 next cycle, no `done`. A new `start` afterwards runs a full 32-result sweep.
5. `start` pulsed again mid-sweep and in the DONE cycle -> ignored. Exactly 32 results, one `done`, and `detect_count` is not cleared.
6. `WAIT_CYCLES` = 1 and 15 -> result spacing is 5 and 19 cycles. The mask/value hold for the full WAIT window, and `crc_enable` is high for exactly 1 cycle per trial.
